qpi_burst_pacer: RTL and testbench
==================================

Name: qpi_burst_pacer

Overview:
Valid/ready stream pacer for the QPI simulation traffic path. It forwards beats in bursts of cfg_burst_len, then inserts cfg_gap idle cycles, then repeats.
It owns no count register. Beat and gap counting are delegated to an external instance of the team's generic counter. The pacer drives that counter's control inputs and consumes its count/terminal outputs.
It sits between the request generator and the QPI channel model.

Parameters:
COUNT_WIDTH, 32, width of cfg_burst_len, cfg_gap and all counter signals; must equal the attached counter's COUNT_WIDTH
DATA_WIDTH, 64, payload width of the in/out stream

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_enable  in  1  run request; sampled in IDLE and at each burst end
cfg_burst_len  in  COUNT_WIDTH  beats per burst; 0 treated as 1
cfg_gap  in  COUNT_WIDTH  idle cycles between bursts; 0 = no gap
in_valid  in  1  upstream beat valid
in_data  in  DATA_WIDTH  upstream payload
in_ready  out  1  upstream beat accepted when in_valid && in_ready
out_valid  out  1  downstream beat valid (registered)
out_data  out  DATA_WIDTH  downstream payload (registered)
out_ready  in  1  downstream accept
ctr_rst  out  1  to counter rst: synchronous reload
ctr_en  out  1  to counter cnt_en
ctr_load  out  COUNT_WIDTH  to counter load_cnt; constant 0
ctr_max  out  COUNT_WIDTH  to counter max_cnt
ctr_count  in  COUNT_WIDTH  from counter count_out (debug/assertions only)
ctr_tc  in  1  from counter terminal_cnt (count == max, combinational)
busy  out  1  state != IDLE
burst_done  out  1  one-cycle pulse, registered, cycle after last beat of a burst accepted

Behaviour:
- Counter contract:
  - ctr_rst=1 reloads the counter to ctr_load (0) on the next edge.
  - Otherwise it increments when ctr_en=1 and count < max, and holds at max.
  - ctr_tc = (count == max).
- Reset (async assert, sync release):
  - state=IDLE; out_valid=0; out_data=0; burst_done=0.
  - burst_m1=0; gap_m1=0; gap_zero=1.
  - Combinational outputs follow IDLE: ctr_rst=1, ctr_en=0, in_ready=0, busy=0.
- States: IDLE, BURST, GAP.
- IDLE:
  - ctr_rst=1, so the counter is held at 0.
  - When cfg_enable=1, latch the config and go to BURST next cycle:
    - burst_m1 = (cfg_burst_len==0) ? 0 : cfg_burst_len-1
    - gap_m1 = cfg_gap-1
    - gap_zero = (cfg_gap==0)
  - Config changes outside IDLE are ignored.
- BURST:
  - ctr_max=burst_m1.
  - in_ready = !out_valid || out_ready.
  - acc = in_valid && in_ready; ctr_en = acc.
  - last = acc && ctr_tc.
  - On last: ctr_rst=1, so the counter reloads 0 in the same edge. Next state:
    - IDLE if cfg_enable=0
    - else BURST if gap_zero
    - else GAP
- GAP:
  - ctr_max=gap_m1; ctr_en=1; in_ready=0.
  - When ctr_tc=1: ctr_rst=1; next state is BURST if cfg_enable=1, else IDLE.
  - GAP lasts exactly cfg_gap cycles.
- ctr_max in IDLE = 0.
- Output register, 1-cycle latency:
  - On acc: out_valid<=1, out_data<=in_data.
  - Else if out_ready: out_valid<=0.
  - No beat is lost or duplicated under backpressure.
  - out_valid may still be 1 after entering GAP or IDLE; it drains normally.
- burst_done <= last.
- Disable mid-burst: the burst completes all remaining beats, then goes to IDLE.
- Disable mid-gap: the gap completes, then goes to IDLE.
- Async rst mid-operation:
  - All registers clear immediately; the in-flight out beat is dropped.
  - ctr_rst=1 combinationally, so the counter clears on the next edge.
- Assertion: in BURST, ctr_count <= burst_m1.

Test Plan:
- burst_len=4, gap=3, in_valid=1, out_ready=1, data 0,1,2,... -> out beats 0-3 on 4 consecutive cycles; in_ready=0 for exactly 3 cycles; beats 4-7 follow; burst_done pulses once per burst, 1 cycle after beat 3/7 accepted.
- burst_len=4, gap=0 -> gapless stream, in_ready never drops, burst_done every 4th beat, state never enters GAP.
- burst_len=0, gap=2 -> single-beat bursts: 1 beat, 2 idle cycles, repeat; ctr_max=0 in BURST.
- burst_len=8, out_ready held 0 for 5 cycles after beat 2 -> in_ready=0 and ctr_count frozen at 3; after release, beats 3-7 emerge in order; total exactly 8 before GAP.
- burst_len=4, cfg_enable dropped after beat 1 -> beats 2,3 still issued; busy falls the cycle after beat 3 accepted; ctr_rst=1 thereafter; no further in_ready.
- Assert rst between clock edges during GAP -> out_valid=0, busy=0, ctr_rst=1 before the next edge; after release with cfg_enable=1, a fresh full burst starts.

Source files
------------

// File: rtl/qpi_burst_pacer.sv
// qpi_burst_pacer: valid/ready stream pacer that forwards bursts of
// cfg_burst_len beats separated by cfg_gap idle cycles. Beat and gap
// counting live in an external generic counter driven through ctr_*.
module qpi_burst_pacer #(
  parameter int COUNT_WIDTH = 32,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_enable,
  input  logic [COUNT_WIDTH-1:0] cfg_burst_len,
  input  logic [COUNT_WIDTH-1:0] cfg_gap,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic                   ctr_rst,
  output logic                   ctr_en,
  output logic [COUNT_WIDTH-1:0] ctr_load,
  output logic [COUNT_WIDTH-1:0] ctr_max,
  input  logic [COUNT_WIDTH-1:0] ctr_count,
  input  logic                   ctr_tc,
  output logic                   busy,
  output logic                   burst_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [COUNT_WIDTH-1:0] burst_m1;
  logic [COUNT_WIDTH-1:0] gap_m1;
  logic                   gap_zero;
  logic                   acc;
  logic                   last;

  // The counter always reloads to zero; only its limit changes per phase.
  assign ctr_load = '0;
  assign busy     = (state != ST_IDLE);

  // Phase control: counter steering, upstream handshake and next state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ctr_en    = 1'b0;
    ctr_rst   = 1'b0;
    ctr_max   = '0;
    acc       = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        ctr_rst = 1'b1;
        if (cfg_enable) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        ctr_max  = burst_m1;
        in_ready = !out_valid || out_ready;
        acc      = in_valid && in_ready;
        ctr_en   = acc;
        last     = acc && ctr_tc;
        if (last) begin
          // Reload in the same edge so the next phase starts counting at 0.
          ctr_rst = 1'b1;
          if (!cfg_enable)   state_nxt = ST_IDLE;
          else if (gap_zero) state_nxt = ST_BURST;
          else               state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        ctr_max = gap_m1;
        ctr_en  = 1'b1;
        if (ctr_tc) begin
          ctr_rst   = 1'b1;
          state_nxt = cfg_enable ? ST_BURST : ST_IDLE;
        end
      end
      default: begin
        ctr_rst   = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and configuration snapshot taken when leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      burst_m1 <= '0;
      gap_m1   <= '0;
      gap_zero <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && cfg_enable) begin
        // A zero burst length behaves as a single-beat burst.
        burst_m1 <= (cfg_burst_len == '0) ? '0 : cfg_burst_len - COUNT_WIDTH'(1);
        gap_m1   <= cfg_gap - COUNT_WIDTH'(1);
        gap_zero <= (cfg_gap == '0);
      end
    end
  end

  // Output beat register (1-cycle latency) and end-of-burst pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= last;
      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // The beat counter must never run past the burst limit while in a burst.
  assert property (@(posedge clk) disable iff (rst)
    (state == ST_BURST) |-> (ctr_count <= burst_m1));

endmodule

// File: tb/tb_qpi_burst_pacer.sv
// Testbench for qpi_burst_pacer: directed scenarios plus randomized traffic,
// checked every cycle against a phase/remaining-count reference model.
module tb_qpi_burst_pacer;
  localparam int CW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic [CW-1:0] cfg_burst_len;
  logic [CW-1:0] cfg_gap;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          ctr_rst;
  logic          ctr_en;
  logic [CW-1:0] ctr_load;
  logic [CW-1:0] ctr_max;
  logic [CW-1:0] ctr_count;
  logic          ctr_tc;
  logic          busy;
  logic          burst_done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model: phase 0 idle, 1 burst, 2 gap; m_left = beats/cycles remaining
  int            m_phase;
  int            m_left;
  int            m_L;
  int            m_G;
  logic          m_ov;
  logic [DW-1:0] m_od;
  logic          m_done;
  logic          m_acc;
  logic [DW-1:0] seq;

  always #5 clk = ~clk;

  qpi_burst_pacer #(.COUNT_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_burst_len(cfg_burst_len),
    .cfg_gap(cfg_gap), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ctr_rst(ctr_rst), .ctr_en(ctr_en), .ctr_load(ctr_load), .ctr_max(ctr_max),
    .ctr_count(ctr_count), .ctr_tc(ctr_tc), .busy(busy), .burst_done(burst_done)
  );

  // generic counter attached to the pacer
  always @(posedge clk) begin
    if (ctr_rst)                            ctr_count <= ctr_load;
    else if (ctr_en && ctr_count < ctr_max) ctr_count <= ctr_count + 1;
  end
  assign ctr_tc = (ctr_count == ctr_max);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_L = 1; m_G = 0;
    m_ov = 1'b0; m_od = '0; m_done = 1'b0; m_acc = 1'b0;
  endtask

  // Drive one cycle of inputs, check all outputs, advance the model, move to next negedge.
  task automatic cyc(input logic v, input logic r, input logic en, input logic [DW-1:0] d);
    logic          exp_ir, acc, last, gend, exp_rst, exp_en;
    logic [CW-1:0] exp_max;
    in_valid = v; out_ready = r; cfg_enable = en; in_data = d;
    #1;
    exp_ir  = (m_phase == 1) && (!m_ov || r);
    acc     = v && exp_ir;
    last    = (m_phase == 1) && acc && (m_left == 1);
    gend    = (m_phase == 2) && (m_left == 1);
    exp_rst = (m_phase == 0) || last || gend;
    exp_en  = (m_phase == 1) ? acc : (m_phase == 2);
    exp_max = (m_phase == 1) ? CW'(m_L - 1) : (m_phase == 2) ? CW'(m_G - 1) : '0;
    chk("in_ready",   64'(in_ready),   64'(exp_ir));
    chk("busy",       64'(busy),       64'(m_phase != 0));
    chk("ctr_rst",    64'(ctr_rst),    64'(exp_rst));
    chk("ctr_en",     64'(ctr_en),     64'(exp_en));
    chk("ctr_max",    64'(ctr_max),    64'(exp_max));
    chk("ctr_load",   64'(ctr_load),   64'(0));
    chk("out_valid",  64'(out_valid),  64'(m_ov));
    chk("out_data",   out_data,        m_od);
    chk("burst_done", 64'(burst_done), 64'(m_done));
    if (m_phase != 0)
      chk("ctr_count", 64'(ctr_count), 64'((m_phase == 1) ? (m_L - m_left) : (m_G - m_left)));
    m_acc = acc;
    if (rst) begin
      model_reset();
    end else begin
      m_done = last;
      if (acc) begin m_ov = 1'b1; m_od = d; end
      else if (r) m_ov = 1'b0;
      case (m_phase)
        0: if (en) begin
             m_L = (cfg_burst_len == 0) ? 1 : int'(cfg_burst_len);
             m_G = int'(cfg_gap);
             m_phase = 1; m_left = m_L;
           end
        1: if (acc) begin
             m_left--;
             if (m_left == 0) begin
               if (!en)           m_phase = 0;
               else if (m_G == 0) m_left = m_L;
               else begin m_phase = 2; m_left = m_G; end
             end
           end
        default: begin
          m_left--;
          if (m_left == 0) begin
            if (en) begin m_phase = 1; m_left = m_L; end
            else m_phase = 0;
          end
        end
      endcase
    end
    @(negedge clk);
  endtask

  // One cycle offering the next sequential payload; the payload advances when accepted.
  task automatic beat(input logic v, input logic r, input logic en);
    cyc(v, r, en, seq);
    if (m_acc) seq++;
  endtask

  task automatic to_idle();
    for (int i = 0; i < 64 && m_phase != 0; i++) beat(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; cfg_enable = 1'b0; cfg_burst_len = '0; cfg_gap = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; seq = '0;
    model_reset();
    @(negedge clk);
    // reset state, enable requested but ignored while in reset
    cyc(1'b1, 1'b1, 1'b1, 64'h55);
    cyc(1'b0, 1'b1, 1'b0, '0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, '0);

    // len 4, gap 3, continuous traffic
    cfg_burst_len = 4; cfg_gap = 3;
    for (int i = 0; i < 24; i++) beat(1'b1, 1'b1, 1'b1);
    to_idle();

    // len 4, gap 0: gapless stream
    cfg_burst_len = 4; cfg_gap = 0;
    for (int i = 0; i < 18; i++) beat(1'b1, 1'b1, 1'b1);
    to_idle();

    // len 0 treated as 1, gap 2
    cfg_burst_len = 0; cfg_gap = 2;
    for (int i = 0; i < 14; i++) beat(1'b1, 1'b1, 1'b1);
    to_idle();

    // len 8 with downstream stalled for 5 cycles after beat 2
    cfg_burst_len = 8; cfg_gap = 2;
    for (int i = 0; i < 20 && !(m_phase == 1 && m_left == 5); i++) beat(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) beat(1'b1, 1'b1, 1'b1);
    to_idle();

    // len 4, enable dropped after beat 1
    cfg_burst_len = 4; cfg_gap = 3;
    for (int i = 0; i < 20 && !(m_phase == 1 && m_left == 2); i++) beat(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) beat(1'b1, 1'b1, 1'b0);

    // randomized traffic, config churn ignored outside idle
    for (int i = 0; i < 500; i++) begin
      cfg_burst_len = CW'($urandom_range(0, 5));
      cfg_gap       = CW'($urandom_range(0, 3));
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 15) != 0), {$urandom, $urandom});
    end
    to_idle();

    // async reset between edges during a gap with an undrained output beat
    cfg_burst_len = 3; cfg_gap = 5;
    for (int i = 0; i < 20 && m_phase != 2; i++) beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_ctr_rst",   64'(ctr_rst),   64'(1));
    model_reset();
    @(negedge clk);
    cyc(1'b1, 1'b1, 1'b1, seq);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) beat(1'b1, 1'b1, 1'b1);
    to_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
